// File: rtl/pwm_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_gen_if
//  Description : Control/status bundle between a duty-cycle source and pwm_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_gen_if #(
   parameter int CNT_W = 8
) ();

   logic             en;
   logic             inc;
   logic             dec;
   logic             load;
   logic [CNT_W:0]   duty_in;
   logic             load_ack;
   logic [CNT_W:0]   duty_out;
   logic             per_start;
   logic             pwm;

   modport master (
      output en, inc, dec, load, duty_in,
      input  load_ack, duty_out, per_start, pwm
   );

   modport slave (
      input  en, inc, dec, load, duty_in,
      output load_ack, duty_out, per_start, pwm
   );

endinterface
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_gen
//  Description : PWM generator with double-buffered duty; shadow duty commits
//                only at a period boundary. Edge-aligned by default;
//                define PWM_CENTER_EN for center-aligned counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen #(
   parameter int CNT_W    = 8,
   parameter int PERIOD   = 255,
   parameter int DUTY_RST = 0,
   parameter int STEP     = 1
) (
   input  wire logic ck,
   input  wire logic rst,
   pwm_gen_if.slave  bus
);

   localparam logic [CNT_W+1:0] c_duty_max   = (CNT_W+2)'(PERIOD + 1);
   localparam logic [CNT_W:0]   c_duty_max_n = (CNT_W+1)'(PERIOD + 1);
   // A step larger than full scale behaves exactly like a full-scale step.
   localparam logic [CNT_W+1:0] c_step       = (STEP > PERIOD + 1) ? c_duty_max
                                                                   : (CNT_W+2)'(STEP);
   localparam logic [CNT_W-1:0] c_cnt_term   = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
   localparam logic [CNT_W:0]   c_duty_rst   = (CNT_W+1)'(DUTY_RST);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W:0]   r_duty_sh;
   logic [CNT_W:0]   r_duty_act;
   logic             r_pend;
   logic             r_pwm;
   logic             r_per_start;
   logic             r_load_ack;

   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W+1:0] w_sh_ext;
   logic [CNT_W+1:0] w_sum;
   logic [CNT_W:0]   w_load_val;
   logic [CNT_W:0]   w_sh_nxt;
   logic             w_pend_nxt;
   logic             w_wrap;

`ifdef PWM_CENTER_EN
   typedef enum logic [0:0] {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   dir_t r_dir;
   dir_t w_dir_nxt;

   assign w_wrap = bus.en && (r_dir == DIR_DOWN) && (r_cnt == c_cnt_one);

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_dir <= DIR_UP;
      end else begin
         r_dir <= w_dir_nxt;
      end
   end

   // Up 0..PERIOD, then down PERIOD-1..1; the wrap returns the count to 0.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_dir_nxt = r_dir;
      if (bus.en) begin
         if (r_dir == DIR_UP) begin
            if (r_cnt == c_cnt_term) begin
               w_cnt_nxt = r_cnt - c_cnt_one;
               w_dir_nxt = DIR_DOWN;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_one;
            end
         end else begin
            w_cnt_nxt = r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) begin
               w_dir_nxt = DIR_UP;
            end
         end
      end
   end
`else
   assign w_wrap = bus.en && (r_cnt == c_cnt_term);

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (bus.en) begin
         w_cnt_nxt = w_wrap ? '0 : r_cnt + c_cnt_one;
      end
   end
`endif

   assign w_sh_ext   = {1'b0, r_duty_sh};
   assign w_sum      = w_sh_ext + c_step;
   assign w_load_val = ({1'b0, bus.duty_in} > c_duty_max) ? c_duty_max_n : bus.duty_in;

   // load beats inc/dec; opposing strobes cancel.
   always_comb begin
      w_sh_nxt = r_duty_sh;
      if (bus.load) begin
         w_sh_nxt = w_load_val;
      end else if (bus.inc && !bus.dec) begin
         w_sh_nxt = (w_sum > c_duty_max) ? c_duty_max_n : w_sum[CNT_W:0];
      end else if (bus.dec && !bus.inc) begin
         w_sh_nxt = (w_sh_ext < c_step) ? '0 : r_duty_sh - c_step[CNT_W:0];
      end
   end

   // A load on the wrap cycle stays pending for the next commit.
   assign w_pend_nxt = bus.load ? 1'b1 : (w_wrap ? 1'b0 : r_pend);

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_duty_sh   <= c_duty_rst;
         r_duty_act  <= c_duty_rst;
         r_pend      <= 1'b0;
         r_pwm       <= 1'b0;
         r_per_start <= 1'b0;
         r_load_ack  <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_duty_sh   <= w_sh_nxt;
         r_pend      <= w_pend_nxt;
         r_pwm       <= bus.en && ({1'b0, r_cnt} < r_duty_act);
         r_per_start <= w_wrap;
         r_load_ack  <= w_wrap && r_pend;
         if (w_wrap) begin
            r_duty_act <= r_duty_sh;
         end
      end
   end

   assign bus.pwm       = r_pwm;
   assign bus.per_start = r_per_start;
   assign bus.load_ack  = r_load_ack;
   assign bus.duty_out  = r_duty_act;

endmodule
`default_nettype wire
